// File: rtl/lfsr_parity_pkg.sv
// Shared PRBS7 + even-parity definitions for the LFSR parity generator and checker.
// State encoding is also exported here for debug visibility.
package lfsr_parity_pkg;

   localparam int LFSR_W = 7;

   typedef enum logic [1:0] {
      ST_HUNT   = 2'd0,
      ST_VERIFY = 2'd1,
      ST_LOCKED = 2'd2
   } state_e;

   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
      return {s[5:0], s[6] ^ s[5]};
   endfunction

   // Returns 1 when the word has odd weight, i.e. fails even parity.
   function automatic logic parity8(input logic [7:0] w);
      return ^w;
   endfunction

endpackage

// File: rtl/lfsr_parity_checker_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear has priority over increment.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/lfsr_parity_checker.sv
// Receive-side checker for the PRBS7+parity word stream.
// Locks via hunt/verify/locked, flags parity and sequence errors.
module lfsr_parity_checker
   import lfsr_parity_pkg::*;
#(
   parameter int LOCK_CNT = 4,
   parameter int LOSS_CNT = 3,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [7:0]       in_word,
   input  logic             clr_cnt,
   output logic             locked,
   output logic             parity_err,
   output logic             seq_err,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] word_count,
   output logic [1:0]       state
);

   localparam logic [3:0] LOCK_C = 4'(LOCK_CNT);
   localparam logic [3:0] LOSS_C = 4'(LOSS_CNT);

   state_e              state_q, state_d;
   logic [LFSR_W-1:0]   exp_q, exp_d;
   logic [3:0]          good_q, good_d;
   logic [3:0]          bad_q, bad_d;
   logic                pe_q, pe_d;
   logic                se_q, se_d;
   logic                err_inc;

   logic [LFSR_W-1:0]   data;
   logic                par_bad;
   logic                miss;
   logic                bad;

   assign data    = in_word[LFSR_W-1:0];
   assign par_bad = parity8(in_word);
   assign miss    = (data != exp_q);
   assign bad     = par_bad | miss;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_HUNT;
         exp_q   <= '0;
         good_q  <= '0;
         bad_q   <= '0;
         pe_q    <= 1'b0;
         se_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         exp_q   <= exp_d;
         good_q  <= good_d;
         bad_q   <= bad_d;
         pe_q    <= pe_d;
         se_q    <= se_d;
      end
   end

   always_comb begin
      state_d = state_q;
      exp_d   = exp_q;
      good_d  = good_q;
      bad_d   = bad_q;
      pe_d    = 1'b0;
      se_d    = 1'b0;
      err_inc = 1'b0;
      if (in_valid) begin
         pe_d = par_bad;
         unique case (state_q)
            ST_HUNT: begin
               if (!par_bad && (data != '0)) begin
                  exp_d   = lfsr_next(data);
                  good_d  = '0;
                  state_d = ST_VERIFY;
               end
            end
            ST_VERIFY: begin
               se_d = miss;
               if (bad) begin
                  state_d = ST_HUNT;
               end else begin
                  exp_d  = lfsr_next(data);
                  good_d = good_q + 4'd1;
                  if (good_d == LOCK_C) begin
                     state_d = ST_LOCKED;
                     bad_d   = '0;
                  end
               end
            end
            ST_LOCKED: begin
               se_d = miss;
               if (bad) begin
                  // Flywheel on the prediction so one corrupt word keeps lock.
                  err_inc = 1'b1;
                  exp_d   = lfsr_next(exp_q);
                  bad_d   = bad_q + 4'd1;
                  if (bad_d == LOSS_C) begin
                     state_d = ST_HUNT;
                  end
               end else begin
                  bad_d = '0;
                  exp_d = lfsr_next(data);
               end
            end
            default: state_d = ST_HUNT;
         endcase
      end
   end

   assign locked     = (state_q == ST_LOCKED);
   assign parity_err = pe_q;
   assign seq_err    = se_q;
   assign state      = state_q;

   sat_counter #(.W(CNT_W)) u_err_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (err_inc),
      .clr   (clr_cnt),
      .count (err_count)
   );

   sat_counter #(.W(CNT_W)) u_word_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (in_valid),
      .clr   (clr_cnt),
      .count (word_count)
   );

endmodule

// File: tb/tb_lfsr_parity_checker.sv
// Directed bench for lfsr_parity_checker: default instance plus a
// narrow-counter instance for saturation and clear priority.
module tb_lfsr_parity_checker;

   logic        clk;
   logic        rst;
   logic        in_valid, clr_cnt;
   logic [7:0]  in_word;
   logic        locked, parity_err, seq_err;
   logic [15:0] err_count, word_count;
   logic [1:0]  state;

   logic        s_valid, s_clr;
   logic [7:0]  s_word;
   logic        s_locked, s_pe, s_se;
   logic [3:0]  s_err, s_words;
   logic [1:0]  s_state;

   int n_tests;
   int n_fail;

   lfsr_parity_checker u_dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_word    (in_word),
      .clr_cnt    (clr_cnt),
      .locked     (locked),
      .parity_err (parity_err),
      .seq_err    (seq_err),
      .err_count  (err_count),
      .word_count (word_count),
      .state      (state)
   );

   lfsr_parity_checker #(.LOCK_CNT(4), .LOSS_CNT(15), .CNT_W(4)) u_sat (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (s_valid),
      .in_word    (s_word),
      .clr_cnt    (s_clr),
      .locked     (s_locked),
      .parity_err (s_pe),
      .seq_err    (s_se),
      .err_count  (s_err),
      .word_count (s_words),
      .state      (s_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [6:0] step(input logic [6:0] s);
      return {s[5:0], s[6] ^ s[5]};
   endfunction

   task automatic send(input logic [7:0] w);
      @(negedge clk);
      in_valid = 1'b1;
      in_word  = w;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send_s(input logic [7:0] w, input logic c);
      @(negedge clk);
      s_valid = 1'b1;
      s_word  = w;
      s_clr   = c;
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      s_clr   = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   logic [6:0] e;
   int         se_seen;

   initial begin
      n_tests  = 0;
      n_fail   = 0;
      rst      = 1'b1;
      in_valid = 1'b0;
      in_word  = 8'h00;
      clr_cnt  = 1'b0;
      s_valid  = 1'b0;
      s_word   = 8'h00;
      s_clr    = 1'b0;
      #12;
      check("rst_state", state, 0);
      check("rst_locked", locked, 0);
      check("rst_cnts", {err_count, word_count}, 0);
      rst = 1'b0;

      // lock onto 0x01, 0x02, 0x04, 0x08, 0x10
      send(8'h81);
      check("t1_verify", state, 1);
      send(8'h82);
      send(8'h84);
      send(8'h88);
      check("t1_not_yet", locked, 0);
      send(8'h90);
      check("t1_locked", locked, 1);
      check("t1_state", state, 2);
      check("t1_err", err_count, 0);
      check("t1_words", word_count, 5);

      // parity hit while locked, then flywheel continues
      send(8'h20);
      check("t2_pe", parity_err, 1);
      check("t2_se", seq_err, 0);
      check("t2_err", err_count, 1);
      check("t2_locked", locked, 1);
      @(posedge clk);
      #1;
      check("t2_pe_pulse", parity_err, 0);
      send(8'h41);
      check("t2_41_se", seq_err, 0);
      send(8'h03);
      check("t2_03_pe", parity_err, 0);
      check("t2_err_hold", err_count, 1);
      check("t2_words", word_count, 8);
      check("t2_still", locked, 1);

      @(negedge clk);
      clr_cnt = 1'b1;
      @(posedge clk);
      #1;
      clr_cnt = 1'b0;
      check("clr_err", err_count, 0);
      check("clr_words", word_count, 0);

      // loss of lock: three good-parity mispredictions (expected 0x06)
      se_seen = 0;
      for (int i = 0; i < 3; i++) begin
         send(8'h81);
         se_seen += int'(seq_err);
         if (i == 1) check("t3_hold", locked, 1);
      end
      check("t3_se_cnt", se_seen, 3);
      check("t3_err", err_count, 3);
      check("t3_locked", locked, 0);
      check("t3_state", state, 0);

      // hunt filtering from reset
      do_reset();
      send(8'h00);
      check("t4_zero_state", state, 0);
      check("t4_zero_pe", parity_err, 0);
      send(8'h01);
      check("t4_bp_state", state, 0);
      check("t4_bp_pe", parity_err, 1);
      check("t4_bp_se", seq_err, 0);
      send(8'h81);
      check("t4_verify", state, 1);

      // relock then async reset mid-cycle
      send(8'h82);
      send(8'h84);
      send(8'h88);
      send(8'h90);
      check("t5_locked", locked, 1);
      send(8'h20);
      check("t5_pe", parity_err, 1);
      check("t5_err", err_count, 1);
      #2;
      rst = 1'b1;
      #1;
      check("t5_rst_locked", locked, 0);
      check("t5_rst_state", state, 0);
      check("t5_rst_pe", parity_err, 0);
      check("t5_rst_err", err_count, 0);
      check("t5_rst_words", word_count, 0);
      @(negedge clk);
      rst = 1'b0;

      // saturation on the narrow instance
      e = 7'h01;
      for (int i = 0; i < 5; i++) begin
         send_s({^e, e}, 1'b0);
         e = step(e);
      end
      check("s_locked", s_locked, 1);
      for (int i = 0; i < 21; i++) begin
         if (i == 14) send_s({^e, e}, 1'b0);
         else send_s({~^e, e}, 1'b0);
         e = step(e);
      end
      check("s_err_sat", s_err, 15);
      check("s_words_sat", s_words, 15);
      check("s_still", s_locked, 1);
      send_s({~^e, e}, 1'b1);
      check("s_clr_pe", s_pe, 1);
      check("s_clr_err", s_err, 0);
      check("s_clr_words", s_words, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
